// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory stall handling.
// Optional performance counters are built only when CTRL_PERF_COUNT_EN is defined.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             retire,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Stall counter saturates at MEM_WAIT_MAX so the timeout compare can only match once per wait.
    localparam int           SC_W    = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(MEM_WAIT_MAX);
    localparam logic [SC_W-1:0] SC_TO  = SC_W'(MEM_WAIT_MAX - 1);

    state_t          state, next_state;
    logic [5:0]      op_q;
    logic [SC_W-1:0] stall_cnt;
    logic            waiting;

    logic       pcw_c, irw_c, iord_c, mr_c, mw_c, rw_c, rd_c, m2r_c, ret_c, ill_c, hlt_c;
    logic [1:0] pcs_c, aop_c, asb_c;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

    always_comb begin
        next_state = state;
        pcw_c = 1'b0; pcs_c = 2'b00; irw_c = 1'b0; iord_c = 1'b0;
        mr_c  = 1'b0; mw_c  = 1'b0;  aop_c = 2'b00; asb_c  = 2'b00;
        rw_c  = 1'b0; rd_c  = 1'b0;  m2r_c = 1'b0; ret_c  = 1'b0;
        ill_c = 1'b0; hlt_c = 1'b0;
        case (state)
            S_FETCH: begin
                mr_c = 1'b1;
                if (mem_ready) begin
                    irw_c      = 1'b1;
                    pcw_c      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // The IR was loaded at the end of FETCH, so the live opcode is valid here.
                asb_c = 2'b11;
                case (opcode)
                    OP_J: begin
                        pcw_c      = 1'b1;
                        pcs_c      = 2'b10;
                        ret_c      = 1'b1;
                        next_state = S_FETCH;
                    end
                    OP_HALT: next_state = S_HALT;
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: next_state = S_EXEC;
                    default: begin
                        ill_c      = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        aop_c      = 2'b10;
                        next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        asb_c      = 2'b10;
                        next_state = S_MEM;
                    end
                    OP_ADDI: begin
                        asb_c      = 2'b10;
                        next_state = S_WB;
                    end
                    OP_BEQ: begin
                        aop_c      = 2'b01;
                        pcs_c      = 2'b01;
                        pcw_c      = zero;
                        ret_c      = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord_c = 1'b1;
                mr_c   = (op_q == OP_LW);
                mw_c   = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        ret_c      = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                rw_c       = 1'b1;
                rd_c       = (op_q == OP_R);
                m2r_c      = (op_q == OP_LW);
                ret_c      = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: hlt_c = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op_q      <= 6'b000000;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                op_q <= opcode;
            if (waiting) begin
                if (stall_cnt != SC_MAX)
                    stall_cnt <= stall_cnt + SC_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    // Every strobe is masked during reset so an in-flight memory access drops immediately.
    assign pc_write    = pcw_c & ~reset;
    assign pc_src      = reset ? 2'b00 : pcs_c;
    assign ir_write    = irw_c & ~reset;
    assign iord        = iord_c & ~reset;
    assign mem_read    = mr_c & ~reset;
    assign mem_write   = mw_c & ~reset;
    assign alu_op      = reset ? 2'b00 : aop_c;
    assign alu_src_b   = reset ? 2'b00 : asb_c;
    assign reg_write   = rw_c & ~reset;
    assign reg_dst     = rd_c & ~reset;
    assign mem_to_reg  = m2r_c & ~reset;
    assign retire      = ret_c & ~reset;
    assign illegal_op  = ill_c & ~reset;
    assign halted      = hlt_c & ~reset;
    assign mem_timeout = (MEM_WAIT_MAX != 0) && waiting && (stall_cnt == SC_TO) && !reset;
    assign state_o     = state;

`ifdef CTRL_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (ret_c)
                instr_count <= instr_count + CNT_W'(1);
            if (state != S_HALT)
                cycle_count <= cycle_count + CNT_W'(1);
        end
    end
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; expected strobes are hand-composed per cycle.
// Counter expectations depend on whether CTRL_PERF_COUNT_EN is defined.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'b000000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, retire, illegal_op, mem_timeout, halted;
    logic [1:0]  pc_src, alu_op, alu_src_b;
    logic [2:0]  state_o;
    logic [31:0] instr_count, cycle_count;
    logic [17:0] ctl;

    int vectors = 0;
    int errors  = 0;

    multicycle_control #(.MEM_WAIT_MAX(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .halted(halted),
        .state_o(state_o), .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_op, alu_src_b,
                  reg_write, reg_dst, mem_to_reg, retire, illegal_op, mem_timeout, halted};

    localparam logic [17:0] PCW = 18'h20000, PCS_BR = 18'h08000, PCS_J = 18'h10000;
    localparam logic [17:0] IRW = 18'h04000, IORD = 18'h02000, MR = 18'h01000, MW = 18'h00800;
    localparam logic [17:0] AOP_SUB = 18'h00200, AOP_FN = 18'h00400;
    localparam logic [17:0] ASB_IMM = 18'h00100, ASB_BR = 18'h00180;
    localparam logic [17:0] RW = 18'h00040, RD = 18'h00020, M2R = 18'h00010, RET = 18'h00008;
    localparam logic [17:0] ILL = 18'h00004, TO = 18'h00002, HLT = 18'h00001;
    localparam logic [17:0] F_GO = PCW | IRW | MR;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, ADDI_OP = 6'b001000;
    localparam logic [5:0] HALT_OP = 6'b111111, BAD_OP = 6'b111110;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic step(input string tag, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [2:0] st, input logic [17:0] ec);
        opcode = op; zero = z; mem_ready = rdy;
        @(negedge clk);
        check({tag, "_state"}, {29'd0, state_o}, {29'd0, st});
        check({tag, "_ctl"}, {14'd0, ctl}, {14'd0, ec});
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with mem_ready high: strobes must stay masked.
        reset = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_ctl", {14'd0, ctl}, 32'd0);
        check("rst_icnt", instr_count, 32'd0);
        check("rst_ccnt", cycle_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // R-type; opcode input changes after DECODE and must not matter.
        step("r_f", R_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("r_d", R_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("r_e", HALT_OP, 1'b0, 1'b1, 3'd2, AOP_FN);
        step("r_wb", LW_OP, 1'b0, 1'b1, 3'd4, RW | RD | RET);

        // LW with two MEM stall cycles.
        step("lw_f", LW_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("lw_d", LW_OP, 1'b0, 1'b0, 3'd1, ASB_BR);
        step("lw_e", R_OP, 1'b0, 1'b1, 3'd2, ASB_IMM);
        step("lw_m0", R_OP, 1'b0, 1'b0, 3'd3, IORD | MR);
        step("lw_m1", R_OP, 1'b0, 1'b0, 3'd3, IORD | MR);
        step("lw_m2", R_OP, 1'b0, 1'b1, 3'd3, IORD | MR);
        step("lw_wb", R_OP, 1'b0, 1'b1, 3'd4, RW | M2R | RET);

        // BEQ taken then not taken.
        step("beq1_f", BEQ_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("beq1_d", BEQ_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("beq1_e", BEQ_OP, 1'b1, 1'b1, 3'd2, AOP_SUB | PCS_BR | PCW | RET);
        step("beq0_f", BEQ_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("beq0_d", BEQ_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("beq0_e", BEQ_OP, 1'b0, 1'b1, 3'd2, AOP_SUB | PCS_BR | RET);

        // Undefined opcode.
        step("ill_f", BAD_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("ill_d", BAD_OP, 1'b0, 1'b1, 3'd1, ASB_BR | ILL);

        // SW interrupted by reset while stalled in MEM.
        step("sw_f", SW_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("sw_d", SW_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("sw_e", SW_OP, 1'b0, 1'b1, 3'd2, ASB_IMM);
        step("sw_m", SW_OP, 1'b0, 1'b0, 3'd3, IORD | MW);
        reset = 1'b1;
        @(negedge clk);
        check("swrst_state", {29'd0, state_o}, 32'd3);
        check("swrst_ctl", {14'd0, ctl}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // FETCH stalled 16 cycles: timeout pulses on the 16th only.
        for (int i = 0; i < 16; i++)
            step($sformatf("to_w%0d", i), J_OP, 1'b0, 1'b0, 3'd0, (i == 15) ? (MR | TO) : MR);
        step("to_go", J_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("j_d", J_OP, 1'b0, 1'b0, 3'd1, ASB_BR | PCW | PCS_J | RET);

        // Fresh run: J, ADDI, SW, HALT.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        step("pj_f", J_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("pj_d", J_OP, 1'b0, 1'b1, 3'd1, ASB_BR | PCW | PCS_J | RET);
        step("pa_f", ADDI_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("pa_d", ADDI_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("pa_e", ADDI_OP, 1'b0, 1'b1, 3'd2, ASB_IMM);
        step("pa_wb", ADDI_OP, 1'b0, 1'b1, 3'd4, RW | RET);
        step("ps_f", SW_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("ps_d", SW_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        step("ps_e", SW_OP, 1'b0, 1'b1, 3'd2, ASB_IMM);
        step("ps_m", SW_OP, 1'b0, 1'b1, 3'd3, IORD | MW | RET);
        step("ph_f", HALT_OP, 1'b0, 1'b1, 3'd0, F_GO);
        step("ph_d", HALT_OP, 1'b0, 1'b1, 3'd1, ASB_BR);
        @(negedge clk);
`ifdef CTRL_PERF_COUNT_EN
        check("halt_icnt", instr_count, 32'd3);
        check("halt_ccnt", cycle_count, 32'd12);
`else
        check("halt_icnt", instr_count, 32'd0);
        check("halt_ccnt", cycle_count, 32'd0);
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            step($sformatf("halt%0d", i), J_OP, 1'b1, 1'b1, 3'd5, HLT);
        @(negedge clk);
`ifdef CTRL_PERF_COUNT_EN
        check("frz_icnt", instr_count, 32'd3);
        check("frz_ccnt", cycle_count, 32'd12);
`else
        check("frz_icnt", instr_count, 32'd0);
        check("frz_ccnt", cycle_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
